// File: rtl/bird_sprite_ctrl.sv
// bird_sprite_ctrl: per-frame bird position latch, ROM addressing, 2-stage pixel pipeline, colour-key transparency
module bird_sprite_ctrl #(
  parameter int          SPRITE_W = 32,
  parameter int          SPRITE_H = 32,
  parameter logic [11:0] KEY_RGB  = 12'h000,
  parameter int          COORD_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] bird_x,
  input  logic [COORD_W-1:0] bird_y,
  output logic [4:0]         rom_row,
  output logic [4:0]         rom_col,
  input  logic [11:0]        rom_pixel,
  output logic               sprite_on,
  output logic [11:0]        sprite_rgb,
  output logic [10:0]        last_opaque_cnt
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;
  logic [COORD_W-1:0] r_bx, r_by, w_bx, w_by;
  logic [COORD_W:0] w_dx, w_dy;
  logic w_latch, w_hit, r_hit_d1, r_hit_d2;
  logic [10:0] r_cnt;
  // Next state, latch decision and hit test; a frame_start pixel already sees the new position and state.
  // Offsets use one extra bit, so a pixel left of/above the sprite yields a huge offset and never wraps into it.
  always_comb begin
    w_latch     = frame_start && (enable || r_state == ACTIVE);
    w_state_nxt = frame_start ? (enable ? ACTIVE : IDLE) : r_state;
    w_bx        = w_latch ? bird_x : r_bx;
    w_by        = w_latch ? bird_y : r_by;
    w_dx        = {1'b0, pix_x} - {1'b0, w_bx};
    w_dy        = {1'b0, pix_y} - {1'b0, w_by};
    w_hit       = (w_state_nxt == ACTIVE) && pix_valid &&
                  (w_dx < (COORD_W+1)'(SPRITE_W)) && (w_dy < (COORD_W+1)'(SPRITE_H));
  end
  // State register and once-per-frame position latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_bx    <= '0;
      r_by    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_bx <= bird_x;
        r_by <= bird_y;
      end
    end
  end
  // Stage 1 drives the ROM address, stage 2 lines the hit flag up with the registered ROM data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_row  <= '0;
      rom_col  <= '0;
      r_hit_d1 <= 1'b0;
      r_hit_d2 <= 1'b0;
    end else begin
      if (w_hit) begin
        rom_row <= w_dy[4:0];
        rom_col <= w_dx[4:0];
      end
      r_hit_d1 <= w_hit;
      r_hit_d2 <= r_hit_d1;
    end
  end
  // Output stage with colour-key transparency
  always_comb begin
    sprite_on  = r_hit_d2 && (rom_pixel != KEY_RGB);
    sprite_rgb = sprite_on ? rom_pixel : 12'h000;
  end
  // Saturating opaque-pixel counter, handed off at frame_start; a coinciding opaque pixel starts the new count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt           <= '0;
      last_opaque_cnt <= '0;
    end else if (frame_start) begin
      last_opaque_cnt <= r_cnt;
      r_cnt           <= {10'd0, sprite_on};
    end else if (sprite_on && r_cnt != 11'd1024) begin
      r_cnt <= r_cnt + 11'd1;
    end
  end
endmodule

// File: tb/tb_bird_sprite_ctrl.sv
// tb_bird_sprite_ctrl: randomized scoreboard bench against a frame-level reference model
module tb_bird_sprite_ctrl;
  logic clk = 0, reset = 1, enable = 0, frame_start = 0, pix_valid = 0;
  logic [9:0] pix_x = 0, pix_y = 0, bird_x = 0, bird_y = 0;
  logic [4:0] rom_row, rom_col;
  logic [11:0] rom_pixel = 0, sprite_rgb;
  logic sprite_on;
  logic [10:0] last_opaque_cnt;

  bird_sprite_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bird_x(bird_x), .bird_y(bird_y),
    .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .sprite_on(sprite_on), .sprite_rgb(sprite_rgb), .last_opaque_cnt(last_opaque_cnt)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sprite ROM contents selectable per test; registered one-cycle read
  int mode = 0;
  logic [11:0] rnd_rom [1024];
  function automatic logic [11:0] rom_f(input logic [4:0] r, input logic [4:0] c);
    if (mode == 0) return {2'b01, r, c};
    if (mode == 1) return 12'hFF0;
    if (mode == 2) return (c < 8) ? 12'h000 : {2'b10, r, c};
    return rnd_rom[{r, c}];
  endfunction
  always @(posedge clk) rom_pixel <= rom_f(rom_row, rom_col);

  // kind 0: output pixel (a=on, b=rgb); kind 1: ROM address (a=row, b=col); kind 2: last_opaque_cnt (a)
  typedef struct {int due; int kind; int a; int b;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) chk("sb_late", 32'(e.due), 32'(cyc));
      else if (e.kind == 0) begin
        chk("sprite_on", 32'(sprite_on), 32'(e.a));
        chk("sprite_rgb", 32'(sprite_rgb), 32'(e.b));
      end else if (e.kind == 1) begin
        chk("rom_row", 32'(rom_row), 32'(e.a));
        chk("rom_col", 32'(rom_col), 32'(e.b));
      end else chk("last_opaque_cnt", 32'(last_opaque_cnt), 32'(e.a));
    end
  end

  // reference model: drawing state, latched position, opaque pixels expected this frame
  bit m_act = 0;
  int m_bx = 0, m_by = 0, m_cnt = 0;

  task automatic step(input bit fs, input bit en, input bit pv, input int px, input int py,
                      input int bx, input int by);
    bit hit, on;
    logic [4:0] r, c;
    frame_start = fs; enable = en; pix_valid = pv;
    pix_x = 10'(px); pix_y = 10'(py); bird_x = 10'(bx); bird_y = 10'(by);
    if (fs) begin
      q.push_back(exp_t'{cyc + 1, 2, (m_cnt > 1024) ? 1024 : m_cnt, 0});
      m_cnt = 0;
      if (en || m_act) begin m_bx = bx; m_by = by; end
      m_act = en;
    end
    hit = m_act && pv && px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32;
    r = 5'(py - m_by);
    c = 5'(px - m_bx);
    if (hit) q.push_back(exp_t'{cyc + 1, 1, int'(r), int'(c)});
    on = hit && rom_f(r, c) != 12'h000;
    q.push_back(exp_t'{cyc + 2, 0, int'(on), on ? int'(rom_f(r, c)) : 0});
    if (on) m_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, enable, 0, 0, 0, bird_x, bird_y);
  endtask

  task automatic frame(input bit en, input int bx, input int by);
    idle(3);
    step(1, en, 0, 0, 0, bx, by);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1, input bit rnd_pv);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        step(0, enable, rnd_pv ? ($urandom_range(0, 3) != 0) : 1'b1, x, y, bird_x, bird_y);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rnd_rom[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    #3;
    chk("rst_sprite_on", 32'(sprite_on), 0);
    chk("rst_sprite_rgb", 32'(sprite_rgb), 0);
    chk("rst_last_cnt", 32'(last_opaque_cnt), 0);
    chk("rst_rom_row", 32'(rom_row), 0);
    chk("rst_rom_col", 32'(rom_col), 0);
    @(posedge clk); #1;
    reset = 0;
    idle(2);
    // no frame_start yet: nothing drawn
    scan(0, 3, 0, 1, 0);
    // corner pixels; first pixel coincides with frame_start
    mode = 0;
    idle(3);
    step(1, 1, 1, 100, 200, 100, 200);
    step(0, 1, 1, 131, 231, 100, 200);
    step(0, 1, 1, 132, 200, 100, 200);
    step(0, 1, 1, 99, 200, 100, 200);
    step(0, 1, 1, 100, 232, 100, 200);
    // fully opaque ROM
    frame(1, 300, 100);
    mode = 1;
    scan(296, 335, 98, 133, 0);
    // left 8 columns transparent
    frame(1, 300, 100);
    mode = 2;
    scan(296, 335, 98, 133, 0);
    // clipped at the 640x480 edge, then near the coordinate limit
    frame(1, 620, 470);
    mode = 1;
    scan(600, 639, 460, 479, 0);
    frame(1, 1020, 0);
    scan(0, 40, 0, 3, 0);
    scan(1012, 1023, 0, 3, 0);
    // sprite scanned twice in one frame saturates the count
    frame(1, 500, 300);
    scan(500, 531, 300, 331, 0);
    scan(500, 531, 300, 331, 0);
    // mid-frame position change waits for the next frame
    frame(1, 100, 200);
    mode = 0;
    scan(96, 135, 198, 215, 0);
    bird_x = 400;
    scan(96, 135, 216, 233, 0);
    scan(396, 435, 216, 233, 0);
    frame(1, 400, 200);
    scan(396, 435, 200, 205, 0);
    scan(96, 135, 200, 205, 0);
    // enable drop mid-frame completes the frame, then idles
    scan(396, 435, 206, 215, 0);
    enable = 0;
    scan(396, 435, 216, 233, 0);
    frame(0, 400, 200);
    scan(396, 435, 200, 233, 0);
    frame(0, 400, 200);
    // random positions, random ROM, random pixel gaps
    mode = 3;
    for (int k = 0; k < 6; k++) begin
      int bx, by;
      bx = $urandom_range(0, 1023);
      by = $urandom_range(0, 1023);
      frame(1, bx, by);
      scan(bx > 6 ? bx - 6 : 0, bx + 38 > 1023 ? 1023 : bx + 38,
           by > 3 ? by - 3 : 0, by + 34 > 1023 ? 1023 : by + 34, 1);
    end
    // async reset while drawing
    frame(1, 100, 200);
    mode = 1;
    step(0, 1, 1, 100, 200, 100, 200);
    step(0, 1, 1, 101, 200, 100, 200);
    step(0, 1, 1, 102, 200, 100, 200);
    chk("pre_reset_on", 32'(sprite_on), 1);
    reset = 1;
    #1;
    q.delete();
    m_act = 0;
    m_cnt = 0;
    chk("reset_sprite_on", 32'(sprite_on), 0);
    chk("reset_sprite_rgb", 32'(sprite_rgb), 0);
    chk("reset_last_cnt", 32'(last_opaque_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    enable = 1;
    scan(98, 110, 199, 202, 0);
    frame(1, 100, 200);
    scan(98, 140, 200, 203, 0);
    frame(1, 100, 200);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
